pipe_ctrl_chain: RTL

Parametrised pipeline backbone for the moquanMIPS core. It generates the fetch PC and chip-enable, and holds the inter-stage pipeline registers for a configurable number of stages. It arbitrates per-stage stall requests into a global stall vector with bubble insertion, and supports a flush that redirects the PC. It replaces the fixed pc_reg plus hard-wired stage registers of the five-stage datapath; the per-stage combinational logic (decode, execute, memory) stays outside and connects between its register slices.

---
 rtl/pipe_ctrl_chain.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl_chain.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_chain
//
// Pipeline backbone for the moquanMIPS core. It generates the fetch PC and
// fetch enable, and it holds one register slice between each pair of adjacent
// stages. The per-stage combinational logic (decode, execute, memory, ...)
// lives outside this block. It reads stage_q_o slice j-1 and drives
// stage_d_i slice j.
//
// Per-stage stall requests are resolved into a global stall vector. A
// requesting stage freezes itself and every stage upstream of it. The first
// slice below the frozen region receives a bubble. A flush clears every
// slice, redirects fetch to new_pc_i, and overrides any stall.
//
// Parameters
//   STAGES   total stages including fetch (2..8); slices are 1..STAGES-1
//   WIDTH    payload width of every slice
//   PC_STEP  PC increment per fetch
//   RESET_PC first fetch address after reset
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active-low
//   stallreq_i   in   [STAGES]          per-stage stall request
//   flush_i      in   discard in-flight slices and redirect fetch
//   new_pc_i     in   [32]              redirect target used on flush
//   pc_o         out  [32]              fetch address
//   ce_o         out  fetch enable
//   stage_d_i    in   [(STAGES-1)*WIDTH] slice j input at [j*WIDTH-1 -: WIDTH]
//   stage_q_o    out  [(STAGES-1)*WIDTH] slice j registered payload
//   stage_v_o    out  [STAGES-1]        slice j valid (bit j-1)
//   stall_o      out  [STAGES]          resolved stall vector (combinational)
//   stall_cnt_o  out  [32]              saturating stall-cycle counter;
//                                       present only when the macro
//                                       PIPE_STALL_CNT_EN is defined
// ---------------------------------------------------------------------------
module pipe_ctrl_chain #(
  parameter int          STAGES   = 5,
  parameter int          WIDTH    = 32,
  parameter logic [31:0] PC_STEP  = 32'd4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [STAGES-1:0]           stallreq_i,
  input  logic                        flush_i,
  input  logic [31:0]                 new_pc_i,
  output logic [31:0]                 pc_o,
  output logic                        ce_o,
  input  logic [(STAGES-1)*WIDTH-1:0] stage_d_i,
  output logic [(STAGES-1)*WIDTH-1:0] stage_q_o,
  output logic [STAGES-2:0]           stage_v_o,
  output logic [STAGES-1:0]           stall_o
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [31:0]                 stall_cnt_o
`endif
);

  localparam int NS = STAGES - 1;

  logic [31:0]         pc_q, pc_d;
  logic                ce_q, ce_d;
  logic [NS*WIDTH-1:0] pay_q, pay_d;
  logic [NS-1:0]       vld_q, vld_d;
  logic [STAGES-1:0]   stall;
  logic [STAGES-1:0]   vld_in;

  // Bit k is set when any stage at or downstream of k requests a stall.
  function automatic logic [STAGES-1:0] resolve_stall(input logic [STAGES-1:0] req);
    logic [STAGES-1:0] s;
    logic              acc;
    s   = '0;
    acc = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc  = acc | req[k];
      s[k] = acc;
    end
    return s;
  endfunction

  always_comb begin
    stall = resolve_stall(stallreq_i);
    if (flush_i) begin
      stall = '0;
    end
  end

  // vld_in[i] is the valid bit feeding slice i+1. For slice 1 this is the
  // fetch enable. For every other slice it is the valid of the slice above.
  assign vld_in = {vld_q, ce_q};

  // Fetch address and enable.
  always_comb begin
    pc_d = pc_q;
    ce_d = 1'b1;
    if (flush_i) begin
      pc_d = new_pc_i;
    end else if (ce_q && !stall[0]) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // Slice update. A slice receives a bubble when its upstream stage is
  // frozen but the slice itself is free to drain. A slice holds when both
  // sides are frozen. Otherwise it advances.
  always_comb begin
    pay_d = pay_q;
    vld_d = vld_q;
    for (int i = 0; i < NS; i++) begin
      if (flush_i) begin
        pay_d[i*WIDTH +: WIDTH] = '0;
        vld_d[i]                = 1'b0;
      end else if (stall[i] && !stall[i+1]) begin
        pay_d[i*WIDTH +: WIDTH] = '0;
        vld_d[i]                = 1'b0;
      end else if (!stall[i]) begin
        pay_d[i*WIDTH +: WIDTH] = stage_d_i[i*WIDTH +: WIDTH];
        vld_d[i]                = vld_in[i];
      end
    end
  end

  // Register boundary: fetch state and all slices.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q  <= RESET_PC;
      ce_q  <= 1'b0;
      pay_q <= '0;
      vld_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ce_q  <= ce_d;
      pay_q <= pay_d;
      vld_q <= vld_d;
    end
  end

  assign pc_o      = pc_q;
  assign ce_o      = ce_q;
  assign stage_q_o = pay_q;
  assign stage_v_o = vld_q;
  assign stall_o   = stall;

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Cycles spent flushing are not stall cycles, even when requests are present.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ce_q && !flush_i && (|stallreq_i)) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
